// File: rtl/seq_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : seq_borrow_subtractor
// Description : Multi-cycle A - B - borrow subtractor, one CHUNK_WID slice per
//               clock with a registered inter-slice borrow; valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_borrow_subtractor #(
    parameter int DATA_WID  = 64,
    parameter int CHUNK_WID = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                InValid,
    output logic                InReady,
    input  logic [DATA_WID-1:0] InputA,
    input  logic [DATA_WID-1:0] InputB,
    input  logic                BorrowInput,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [DATA_WID-1:0] Difference,
    output logic                BorrowOutput,
    output logic                Overflow
);

    localparam int c_numSlices = DATA_WID / CHUNK_WID;
    localparam int c_cntWid    = (c_numSlices > 1) ? $clog2(c_numSlices) : 1;
    localparam logic [c_cntWid-1:0] c_lastSlice = c_cntWid'(c_numSlices - 1);
    localparam int c_msb       = DATA_WID - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [DATA_WID-1:0]  r_opA;
    logic [DATA_WID-1:0]  r_opB;
    logic [c_cntWid-1:0]  r_count;
    logic                 r_borrow;
    logic                 r_borrowOut;
    logic                 r_overflow;
    logic [CHUNK_WID-1:0] r_diffSlice [c_numSlices];

    logic [CHUNK_WID-1:0] w_sliceA [c_numSlices];
    logic [CHUNK_WID-1:0] w_sliceB [c_numSlices];
    logic [CHUNK_WID:0]   w_sub;
    logic                 w_lastSlice;
    logic                 w_overflow;

    generate
        for (genvar i = 0; i < c_numSlices; i++) begin : g_slice
            assign w_sliceA[i] = r_opA[i*CHUNK_WID +: CHUNK_WID];
            assign w_sliceB[i] = r_opB[i*CHUNK_WID +: CHUNK_WID];
            assign Difference[i*CHUNK_WID +: CHUNK_WID] = r_diffSlice[i];
        end
    endgenerate

    // The extra top bit of the zero-extended subtract is the slice borrow-out
    assign w_sub = {1'b0, w_sliceA[r_count]} - {1'b0, w_sliceB[r_count]}
                 - {{CHUNK_WID{1'b0}}, r_borrow};
    assign w_lastSlice = (r_count == c_lastSlice);
    assign w_overflow  = (r_opA[c_msb] ^ r_opB[c_msb]) & (w_sub[CHUNK_WID-1] ^ r_opA[c_msb]);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (InValid)     w_nextState = RUN;
            RUN:     if (w_lastSlice) w_nextState = DONE;
            DONE:    if (OutReady)    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_opA       <= '0;
            r_opB       <= '0;
            r_count     <= '0;
            r_borrow    <= 1'b0;
            r_borrowOut <= 1'b0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < c_numSlices; i++) begin
                r_diffSlice[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (InValid) begin
                        r_opA    <= InputA;
                        r_opB    <= InputB;
                        r_count  <= '0;
                        r_borrow <= BorrowInput;
                    end
                end
                RUN: begin
                    r_diffSlice[r_count] <= w_sub[CHUNK_WID-1:0];
                    r_borrow             <= w_sub[CHUNK_WID];
                    r_count              <= w_lastSlice ? '0 : r_count + 1'b1;
                    // Final slice holds the MSB, so flags are settled here
                    if (w_lastSlice) begin
                        r_borrowOut <= w_sub[CHUNK_WID];
                        r_overflow  <= w_overflow;
                    end
                end
                default: ;
            endcase
        end
    end

    assign InReady      = (r_state == IDLE);
    assign OutValid     = (r_state == DONE);
    assign BorrowOutput = r_borrowOut;
    assign Overflow     = r_overflow;

endmodule
`default_nettype wire

// File: doc/seq_borrow_subtractor.md
# seq_borrow_subtractor

Multi-cycle DATA_WID-bit subtractor that computes InputA − InputB − BorrowInput, one CHUNK_WID-bit slice per clock with the borrow rippled between slices through a register. It is the subtract-direction companion to the combinational ripple-carry adder. It trades latency for a short critical path and sits behind a valid/ready handshake on both input and output, so it can be dropped into pipelined datapaths.

## Interface
Parameters:
- DATA_WID, 64, operand and result width; must be a multiple of CHUNK_WID.
- CHUNK_WID, 16, bits processed per cycle; N = DATA_WID/CHUNK_WID slices (default 4).

Ports:
- Clock  input  1  rising-edge clock; single clock domain.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  operands present.
- InReady  output  1  block can accept operands.
- InputA  input  DATA_WID  minuend.
- InputB  input  DATA_WID  subtrahend.
- BorrowInput  input  1  borrow-in, subtracted at bit 0.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts result.
- Difference  output  DATA_WID  (A − B − BorrowInput) mod 2^DATA_WID.
- BorrowOutput  output  1  1 when A < B + BorrowInput as unsigned values.
- Overflow  output  1  two's-complement signed overflow of the subtraction.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: InReady=1, OutValid=0. InValid=1 at an edge is an accept. On accept, InputA, InputB and BorrowInput are registered, the slice counter is cleared, the borrow register is loaded with BorrowInput, and the FSM moves to RUN.
- RUN: InReady=0. Each edge processes slice k = counter: bits [k·CHUNK_WID +: CHUNK_WID] of A − B − borrow go into the Difference register. The borrow register takes the slice borrow-out, and the counter increments. After slice N−1, the FSM moves to DONE.
- DONE: OutValid=1. Difference, BorrowOutput and Overflow are stable and held. BorrowOutput is the final borrow register value. Overflow = (A[MSB] ≠ B[MSB]) & (Difference[MSB] ≠ A[MSB]), using the captured operands.
- DONE with OutReady=1 at an edge completes the output handshake and returns the FSM to IDLE.
- InValid is ignored outside IDLE. Operand changes after accept have no effect.
- No same-cycle output-complete/new-accept: InReady is 0 in DONE.
- Counter width is ceil(log2(N)), with a minimum of 1 bit. With N=1, RUN lasts exactly one cycle.
- Reset: FSM→IDLE. InReady=1 from the first cycle after reset. OutValid=0, Difference=0, BorrowOutput=0, Overflow=0, counter=0, borrow register=0.
- Reset in RUN or DONE aborts the operation. No OutValid is produced for the aborted operation, and the result is discarded.

## Timing
- Accept at edge E0 (IDLE, InValid=1).
- Slice k is written at edge E(k+1).
- OutValid rises after edge EN and is high in the cycle following EN. Latency is N cycles from accept (4 for the defaults).
- Minimum initiation interval is N+2 cycles: the accept cycle, N RUN cycles, and at least one DONE cycle, with the FSM back in IDLE after the output handshake.
- Outputs are registered and have no combinational paths from inputs, except that InReady and OutValid are decoded from the state register only.
- OutReady held low keeps the FSM in DONE indefinitely with all outputs constant.
- The critical path is one CHUNK_WID-bit subtract plus the borrow mux.

## Test plan
- A=1, B=1, BorrowInput=0 → Difference=0, BorrowOutput=0, Overflow=0. OutValid rises 4 cycles after accept.
- A=0, B=1, BorrowInput=0 → Difference=0xFFFF_FFFF_FFFF_FFFF, BorrowOutput=1, Overflow=0.
- A=7, B=1, BorrowInput=1 → Difference=5, BorrowOutput=0. Then A=0x0000_0000_0001_0000, B=1 → Difference=0x0000_0000_0000_FFFF, which checks the borrow crossing the slice boundary.
- Signed overflow: A=0x8000_0000_0000_0000, B=1 → Difference=0x7FFF_FFFF_FFFF_FFFF, Overflow=1, BorrowOutput=0.
- Backpressure: hold OutReady=0 for 5 cycles in DONE while toggling InValid, InputA and InputB. Outputs must stay constant, InReady must stay 0, and there must be no second accept. On OutReady=1, IDLE follows on the next cycle.
- Assert Reset for one cycle during RUN slice 2. Required response: OutValid never asserted, all outputs 0, InReady=1 on the cycle after reset deasserts. A new operation, 3 − 5, then gives 0xFFFF_FFFF_FFFF_FFFE with BorrowOutput=1.
